calc_result_display: RTL and testbench
======================================

# calc_result_display

Downstream stage of the switch-driven four-function calculator. It takes the 8-bit unsigned result bus that drives the LEDs and converts it to decimal with a sequential shift-add-3 (double-dabble) converter. It then time-multiplexes the result onto the Basys 3 four-digit, common-anode seven-segment display with leading-zero blanking. Subtract underflow wraps, e.g. 3−5 gives 8'hFE, and is shown as unsigned 254.

## Interface
- REFRESH_DIV, 100000: clocks per digit slot. At 100 MHz this gives a 1 kHz digit rate and a 250 Hz frame rate. Minimum legal value is 2.
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- value  input  8  calculator result, unsigned 0–255, sampled only in IDLE
- seg  output  7  {g,f,e,d,c,b,a}, active low, registered
- an  output  4  digit anodes, active low, one-hot-low, registered; an[0] is rightmost
- dp  output  1  decimal point, constant 1 (off)
- busy  output  1  high while a conversion is in progress (SHIFT or DONE)

## Operation
- Internal registers:
  - cur: last converted value; reset 0.
  - disp_h, disp_t, disp_o: displayed BCD digits; reset 0.
  - shreg: 8-bit shift register.
  - bcd: 12-bit work register.
  - cnt: 3-bit iteration counter.
  - idx: 2-bit digit index.
  - rcnt: refresh counter.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: if value != cur, then shreg<=value, bcd<=0, cnt<=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each nibble of bcd that is ≥5 gets +3, then {bcd,shreg} shifts left by one. Then cnt<=cnt+1. When cnt==7, go to DONE.
  - DONE: {disp_h,disp_t,disp_o}<=bcd, cur<=the captured value, go to IDLE.
- value is ignored outside IDLE. A change made during SHIFT or DONE is picked up on the first IDLE cycle after DONE.
- Display digits are never partially updated. All three change together on the DONE edge.
- Scan:
  - rcnt counts 0..REFRESH_DIV-1. On wrap to 0, idx advances 0→1→2→3→0.
  - an = ~(4'b0001<<idx).
  - idx0 shows ones, idx1 tens, idx2 hundreds.
  - idx3 is always blank (seg=7'h7F).
- Blanking:
  - hundreds is blank when disp_h==0.
  - tens is blank when disp_h==0 and disp_t==0.
  - ones is never blank.
  - A blank slot still drives its an low with seg=7'h7F.
- Segment codes, digit 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. A BCD nibble >9 cannot occur.

## Timing
- Reset (async, any time, including mid-conversion):
  - FSM goes to IDLE; cur, disp_*, rcnt and idx are cleared.
  - Outputs: an=4'b1111, seg=7'h7F, dp=1, busy=0.
  - Any partial conversion is discarded.
- First edge after reset release: an=4'b1110, seg=1000000, so the display shows "0".
- Conversion latency, counting the edge where IDLE samples a changed value as edge 0:
  - busy rises after edge 0.
  - SHIFT occupies edges 1–8.
  - DONE is applied at edge 9, when disp_* updates.
  - busy falls after edge 9.
  - The earliest next sample is edge 10.
- seg and an are registered from idx and disp_* of the previous cycle. A new digit is visible one edge after DONE, in the currently scanned slot.
- Scan period is 4·REFRESH_DIV clocks. The FSM never stalls the scan.
- If value equals cur, there is no conversion and busy stays low. After reset, value=0 never triggers a conversion.

## Test plan
- Reset and idle:
  - Stimulus: assert rst with value=0, then release.
  - Required: while in reset, an=1111, seg=7F, busy=0. After release, with REFRESH_DIV=4, an cycles 1110, 1101, 1011, 0111 every 4 clocks. seg is 1000000 on an=1110 and 7F on the other slots. busy is never set.
- Full-scale conversion:
  - Stimulus: value=255.
  - Required: busy is high for exactly 9 cycles. disp = 2,5,5. Slots show 0100100 (hundreds), 0010010 (tens), 0010010 (ones), and blank.
- Leading-zero blanking:
  - Stimulus: value=7, then value=40.
  - Required for 7: only the ones slot shows 1111000; hundreds and tens are 7F.
  - Required for 40: tens shows 0011001, ones shows 1000000, hundreds is 7F.
- Change while busy:
  - Stimulus: value=100, then value=9 at edge 3 of the conversion.
  - Required: the display first becomes 1,0,0 at edge 9. A new conversion starts at edge 10, and the display becomes 9 at edge 19.
- Reset mid-conversion:
  - Stimulus: value=200, then assert rst during SHIFT.
  - Required: outputs take reset values immediately and disp stays 0. After release, with value still 200, a fresh 9-cycle conversion shows 2,0,0.
- Underflow and return to zero:
  - Stimulus: value=8'hFE, then value=0.
  - Required: the display shows 2,5,4, then 0 (ones only), with busy pulsing 9 cycles each time.

Source files
------------

// File: rtl/calc_result_display_if.sv
// calc_result_display_if
//   Groups the calculator result input and the seven-segment display outputs.
//   value : 8-bit unsigned calculator result (driven by the master)
//   seg   : {g,f,e,d,c,b,a}, active low
//   an    : digit anodes, active low, an[0] is the rightmost digit
//   dp    : decimal point, active low (always off)
//   busy  : high while a binary-to-BCD conversion is in progress
interface calc_result_display_if;
  logic [7:0] value;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  modport master (output value, input seg, an, dp, busy);
  modport slave  (input value, output seg, an, dp, busy);
endinterface

// File: rtl/calc_result_display.sv
// calc_result_display
//   Converts an 8-bit unsigned result to three BCD digits with a sequential
//   shift-add-3 converter and scans them onto a four-digit common-anode
//   seven-segment display with leading-zero blanking.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : calc_result_display_if.slave (value in; seg, an, dp, busy out)
//   REFRESH_DIV : clocks per digit slot (minimum 2)
module calc_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  calc_result_display_if.slave        bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    cap_q, cap_d;      // value captured at conversion start
  logic [7:0]    shreg_q, shreg_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [11:0]   bcd_adj;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    disp_h_q, disp_h_d;
  logic [3:0]    disp_t_q, disp_t_d;
  logic [3:0]    disp_o_q, disp_o_d;
  logic [1:0]    idx_q, idx_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction: any BCD nibble >= 5 would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5) begin
        bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next-state logic.
  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cap_d    = cap_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    disp_h_d = disp_h_q;
    disp_t_d = disp_t_q;
    disp_o_d = disp_o_q;

    case (state_q)
      S_IDLE: begin
        if (bus.value != cur_q) begin
          cap_d   = bus.value;
          shreg_d = bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // All three digits commit together so the display never shows a mix.
        disp_h_d = bcd_q[11:8];
        disp_t_d = bcd_q[7:4];
        disp_o_d = bcd_q[3:0];
        cur_d    = cap_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Digit scan and segment selection; runs independently of the converter.
  always_comb begin
    rcnt_d = rcnt_q + RW'(1);
    idx_d  = idx_q;
    if (rcnt_q == RCNT_LAST) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    an_d = ~(4'b0001 << idx_q);

    case (idx_q)
      2'd0:    seg_d = seg_code(disp_o_q);
      2'd1:    seg_d = (disp_h_q == 4'd0 && disp_t_q == 4'd0) ? SEG_BLANK
                                                              : seg_code(disp_t_q);
      2'd2:    seg_d = (disp_h_q == 4'd0) ? SEG_BLANK : seg_code(disp_h_q);
      default: seg_d = SEG_BLANK;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  // NOTE: all registers, including the work registers, are reset so a
  // conversion interrupted by reset leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      cap_q    <= '0;
      shreg_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      disp_h_q <= '0;
      disp_t_q <= '0;
      disp_o_q <= '0;
      idx_q    <= '0;
      rcnt_q   <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= 4'b1111;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cap_q    <= cap_d;
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      disp_h_q <= disp_h_d;
      disp_t_q <= disp_t_d;
      disp_o_q <= disp_o_d;
      idx_q    <= idx_d;
      rcnt_q   <= rcnt_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.dp   = 1'b1;
  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_result_display.sv
// tb_calc_result_display
//   Randomized and directed stimulus for calc_result_display with
//   REFRESH_DIV=4. Expected digits come from decimal arithmetic on the
//   applied value; expected busy length and scan order come from the timing
//   rules of the block.
module tb_calc_result_display;

  localparam int RD = 4;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   shown        = 0;   // value the display is expected to hold

  calc_result_display_if bus ();

  calc_result_display #(.REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Expected segment pattern for a slot (0=ones ... 3=unused) showing v.
  function automatic logic [6:0] exp_seg(input int v, input int slot);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (slot)
      0:       return SEG_TAB[o];
      1:       return (h == 0 && t == 0) ? BLANK : SEG_TAB[t];
      2:       return (h == 0) ? BLANK : SEG_TAB[h];
      default: return BLANK;
    endcase
  endfunction

  function automatic int slot_of(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Waits up to a few cycles for busy to rise; returns at that negedge.
  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at a negedge where busy is high; counts that cycle plus the rest.
  task automatic measure_busy(output int n);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
    end
  endtask

  // Samples one full scan frame worth of cycles and checks every slot.
  task automatic scan_check(input int v, input string name);
    int slot;
    for (int i = 0; i < 4 * RD; i++) begin
      @(negedge clk);
      slot = slot_of(bus.an);
      tests_run++;
      if (slot < 0) begin
        tests_failed++;
        $display("FAIL %s an: got %b, required one-hot-low", name, bus.an);
      end else if (bus.seg !== exp_seg(v, slot) || bus.dp !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s slot%0d seg: got %b dp %b, required %b dp 1",
                 name, slot, bus.seg, bus.dp, exp_seg(v, slot));
      end
    end
  endtask

  task automatic run_conv(input int v, input string name);
    bit ok;
    int n;
    bus.value = 8'(v);
    wait_busy(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s busy_rise: got 0, required 1", name);
      return;
    end
    measure_busy(n);
    tests_run++;
    if (n != 9) begin
      tests_failed++;
      $display("FAIL %s busy_len: got %0d, required 9", name, n);
    end
    shown = v;
    scan_check(v, name);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.value = 8'd0;
    @(negedge clk);
    tests_run++;
    if (bus.an !== 4'b1111 || bus.seg !== BLANK || bus.busy !== 1'b0 || bus.dp !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_out: got an=%b seg=%b busy=%b dp=%b, required 1111 1111111 0 1",
               bus.an, bus.seg, bus.busy, bus.dp);
    end
    rst = 1'b0;
    for (int i = 0; i < 4 * RD; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.an !== ~(4'b0001 << (i / RD)) || bus.seg !== exp_seg(0, i / RD)
          || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_scan[%0d]: got an=%b seg=%b busy=%b, required an=%b seg=%b busy=0",
                 i, bus.an, bus.seg, bus.busy, ~(4'b0001 << (i / RD)), exp_seg(0, i / RD));
      end
    end
    shown = 0;
  endtask

  task automatic test_full_scale;
    run_conv(255, "full_scale");
  endtask

  task automatic test_blanking;
    run_conv(7, "blank_7");
    run_conv(40, "blank_40");
  endtask

  task automatic test_change_while_busy;
    bit ok;
    int n;
    int slot;
    bus.value = 8'd100;
    wait_busy(ok);                 // after edge 0
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL chg busy_rise: got 0, required 1");
      return;
    end
    @(negedge clk);                // after edge 1
    @(negedge clk);                // after edge 2
    bus.value = 8'd9;              // seen by edge 3, ignored until IDLE
    n = 3;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
    end
    tests_run++;
    if (n != 9) begin
      tests_failed++;
      $display("FAIL chg busy_len1: got %0d, required 9", n);
    end
    @(negedge clk);                // after edge 10: 100 visible, new conversion running
    slot = slot_of(bus.an);
    tests_run++;
    if (bus.busy !== 1'b1 || slot < 0 || bus.seg !== exp_seg(100, slot)) begin
      tests_failed++;
      $display("FAIL chg mid: got busy=%b an=%b seg=%b, required busy=1 seg for 100",
               bus.busy, bus.an, bus.seg);
    end
    measure_busy(n);
    tests_run++;
    if (n != 9) begin
      tests_failed++;
      $display("FAIL chg busy_len2: got %0d, required 9", n);
    end
    shown = 9;
    scan_check(9, "chg_9");
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    bus.value = 8'd200;
    wait_busy(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rstmid busy_rise: got 0, required 1");
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.an !== 4'b1111 || bus.seg !== BLANK || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid out: got an=%b seg=%b busy=%b, required 1111 1111111 0",
               bus.an, bus.seg, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);                // first edge after release: edge 0 of new conversion
    tests_run++;
    if (bus.busy !== 1'b1 || bus.an !== 4'b1110 || bus.seg !== SEG_TAB[0]) begin
      tests_failed++;
      $display("FAIL rstmid restart: got busy=%b an=%b seg=%b, required 1 1110 1000000",
               bus.busy, bus.an, bus.seg);
    end
    measure_busy(n);
    tests_run++;
    if (n != 9) begin
      tests_failed++;
      $display("FAIL rstmid busy_len: got %0d, required 9", n);
    end
    shown = 200;
    scan_check(200, "rstmid_200");
  endtask

  task automatic test_underflow;
    run_conv(254, "uflow_254");
    run_conv(0, "zero");
  endtask

  task automatic check_no_change(input string name);
    int highs = 0;
    bus.value = 8'(shown);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) highs++;
    end
    tests_run++;
    if (highs != 0) begin
      tests_failed++;
      $display("FAIL %s busy: got %0d busy cycles, required 0", name, highs);
    end
  endtask

  task automatic test_no_change;
    check_no_change("no_change");
    scan_check(shown, "no_change_disp");
  endtask

  task automatic test_random;
    int v;
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(0, 255));
      if (v == shown) check_no_change("rand_same");
      else            run_conv(v, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_blanking();
    test_change_while_busy();
    test_reset_mid();
    test_underflow();
    test_no_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
